// File: rtl/mac_tx_gmii.sv
// Store-and-forward GMII transmitter: 32-bit word FIFO in, preamble/SFD/data/pad/FCS out, IFG enforced.
// A frame starts one cycle after its eof word lands; mac_tx_stop is high while the word FIFO is full.
module mac_tx_gmii #(
  parameter int FIFO_AW    = 9,
  parameter int IFG_CYCLES = 12
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mac_tx_we,
  input  logic [31:0] mac_tx_data,
  input  logic [3:0]  mac_tx_eof,
  output logic        mac_tx_stop,
  output logic [7:0]  gmii_txd,
  output logic        gmii_tx_en,
  output logic        gmii_tx_er
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL = {1'b1, {FIFO_AW{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_SFD, S_DATA, S_PAD, S_FCS, S_IFG
  } state_t;

  logic [35:0]        mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   occ;
  logic [FIFO_AW:0]   pkt_count;
  logic               push, pop, pop_req;
  logic [31:0]        head_dat;
  logic [3:0]         head_eof;

  state_t      state;
  logic [7:0]  cnt;
  logic [31:0] word_q;
  logic [3:0]  eof_q;
  logic [1:0]  bi;
  logic        frame_end;
  logic [10:0] byte_cnt;
  logic [31:0] crc;

  logic [7:0]  cur_byte;
  logic        cur_last, emit_data, go_pre, pad_needed;
  logic [10:0] byte_cnt_inc;
  logic [31:0] crc_fin;

  function automatic logic [1:0] last_idx(input logic [3:0] e);
    if (e[3])      return 2'd0;
    else if (e[2]) return 2'd1;
    else if (e[1]) return 2'd2;
    else           return 2'd3;
  endfunction

  // Reflected CRC-32, one byte, LSB first.
  function automatic logic [31:0] crc8(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  assign mac_tx_stop = (occ == FULL);
  assign push        = mac_tx_we && !mac_tx_stop;
  assign pop         = pop_req && (occ != '0);
  assign {head_eof, head_dat} = mem[rd_ptr];
  assign gmii_tx_er  = 1'b0;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {mac_tx_eof, mac_tx_data};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      pkt_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
      case ({push && (mac_tx_eof != 4'b0), pop && (head_eof != 4'b0)})
        2'b10:   pkt_count <= pkt_count + 1'b1;
        2'b01:   pkt_count <= pkt_count - 1'b1;
        default: pkt_count <= pkt_count;
      endcase
    end
  end

  always_comb begin
    cur_byte = word_q[31:24];
    case (bi)
      2'd1:    cur_byte = word_q[23:16];
      2'd2:    cur_byte = word_q[15:8];
      2'd3:    cur_byte = word_q[7:0];
      default: cur_byte = word_q[31:24];
    endcase
  end

  // The next word is popped on the edge that emits the current word's last byte, so DATA never stalls.
  assign cur_last     = (bi == last_idx(eof_q));
  assign emit_data    = (state == S_SFD) || (state == S_DATA && !frame_end);
  assign pop_req      = (state == S_PRE && cnt == 8'd7) || (emit_data && cur_last && eof_q == 4'b0);
  assign go_pre       = (pkt_count != '0) &&
                        (state == S_IDLE || (state == S_IFG && cnt >= 8'(IFG_CYCLES)));
  assign pad_needed   = (byte_cnt < 11'd60);
  assign byte_cnt_inc = (byte_cnt == 11'h7FF) ? byte_cnt : byte_cnt + 11'd1;
  assign crc_fin      = ~crc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      word_q     <= '0;
      eof_q      <= '0;
      bi         <= '0;
      frame_end  <= 1'b0;
      byte_cnt   <= '0;
      crc        <= '1;
      gmii_txd   <= 8'h00;
      gmii_tx_en <= 1'b0;
    end else if (go_pre) begin
      state      <= S_PRE;
      cnt        <= 8'd1;
      gmii_txd   <= 8'h55;
      gmii_tx_en <= 1'b1;
      crc        <= '1;
      byte_cnt   <= '0;
      frame_end  <= 1'b0;
    end else begin
      case (state)
        S_PRE: begin
          if (cnt == 8'd7) begin
            state    <= S_SFD;
            gmii_txd <= 8'hD5;
            word_q   <= head_dat;
            eof_q    <= head_eof;
            bi       <= 2'd0;
          end else begin
            cnt      <= cnt + 8'd1;
            gmii_txd <= 8'h55;
          end
        end
        S_SFD, S_DATA, S_PAD: begin
          if (emit_data) begin
            state    <= S_DATA;
            gmii_txd <= cur_byte;
            crc      <= crc8(crc, cur_byte);
            byte_cnt <= byte_cnt_inc;
            if (cur_last) begin
              if (eof_q != 4'b0) begin
                frame_end <= 1'b1;
              end else begin
                word_q <= head_dat;
                eof_q  <= head_eof;
                bi     <= 2'd0;
              end
            end else begin
              bi <= bi + 2'd1;
            end
          end else if (pad_needed) begin
            state    <= S_PAD;
            gmii_txd <= 8'h00;
            crc      <= crc8(crc, 8'h00);
            byte_cnt <= byte_cnt_inc;
          end else begin
            state    <= S_FCS;
            gmii_txd <= crc_fin[7:0];
            cnt      <= 8'd1;
          end
        end
        S_FCS: begin
          if (cnt == 8'd4) begin
            state      <= S_IFG;
            gmii_txd   <= 8'h00;
            gmii_tx_en <= 1'b0;
            cnt        <= 8'd1;
          end else begin
            gmii_txd <= crc_fin[{cnt[1:0], 3'b000} +: 8];
            cnt      <= cnt + 8'd1;
          end
        end
        S_IFG: begin
          if (cnt >= 8'(IFG_CYCLES)) state <= S_IDLE;
          else                       cnt   <= cnt + 8'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_tx_gmii.sv
// Directed bench for mac_tx_gmii: table of frame shapes plus sequences for IFG, same-edge pkt_count, FIFO full and mid-frame reset.
module tb_mac_tx_gmii;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        mac_tx_we = 1'b0;
  logic [31:0] mac_tx_data = '0;
  logic [3:0]  mac_tx_eof = '0;
  logic        mac_tx_stop;
  logic [7:0]  gmii_txd;
  logic        gmii_tx_en;
  logic        gmii_tx_er;

  mac_tx_gmii #(.FIFO_AW(4), .IFG_CYCLES(12)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .mac_tx_we   (mac_tx_we),
    .mac_tx_data (mac_tx_data),
    .mac_tx_eof  (mac_tx_eof),
    .mac_tx_stop (mac_tx_stop),
    .gmii_txd    (gmii_txd),
    .gmii_tx_en  (gmii_tx_en),
    .gmii_tx_er  (gmii_tx_er)
  );

  always #4 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vec_cnt = 0;
  int miss_cnt = 0;

  // GMII capture: every contiguous tx_en run is one frame.
  logic [7:0] rx_q[$];
  int fr_start[$], fr_len[$], fr_first[$], fr_last[$];
  int cur_len = 0, last_seen = 0;
  bit in_frame = 1'b0;

  always @(negedge clk) begin
    if (gmii_tx_en) begin
      if (!in_frame) begin
        in_frame = 1'b1;
        fr_first.push_back(cyc);
        fr_start.push_back(rx_q.size());
        cur_len = 0;
      end
      rx_q.push_back(gmii_txd);
      cur_len++;
      last_seen = cyc;
    end else if (in_frame) begin
      in_frame = 1'b0;
      fr_len.push_back(cur_len);
      fr_last.push_back(last_seen);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d miscompares=%0d", vec_cnt, miss_cnt);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    logic fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[0] ^ d[i];
      r  = {1'b0, r[31:1]} ^ (fb ? 32'hEDB8_8320 : 32'h0);
    end
    return r;
  endfunction

  function automatic logic [7:0] pat(input int f, input int i);
    return 8'((f * 37 + i * 13 + 5) & 255);
  endfunction

  function automatic int nvalid(input logic [3:0] e);
    if (e[0]) return 4;
    if (e[1]) return 3;
    if (e[2]) return 2;
    if (e[3]) return 1;
    return 4;
  endfunction

  logic [31:0] wq[$];
  logic [3:0]  eq[$];
  logic [7:0]  exp_q[$];
  int          last_wr_cyc = 0;

  // Invalid tail bytes of the final word carry 0xEE so leaked garbage shows up.
  task automatic build(input int f, input int nw, input logic [3:0] e);
    logic [31:0] w;
    logic [7:0]  b;
    wq.delete(); eq.delete(); exp_q.delete();
    for (int k = 0; k < nw; k++) begin
      w = '0;
      for (int j = 0; j < 4; j++) begin
        if (k == nw - 1 && j >= nvalid(e)) b = 8'hEE;
        else begin
          b = pat(f, 4 * k + j);
          exp_q.push_back(b);
        end
        w[31 - 8 * j -: 8] = b;
      end
      wq.push_back(w);
      eq.push_back((k == nw - 1) ? e : 4'b0);
    end
  endtask

  task automatic write_word(input logic [31:0] d, input logic [3:0] e);
    int k = 0;
    @(negedge clk);
    while (mac_tx_stop && k < 500) begin
      mac_tx_we = 1'b0;
      @(negedge clk);
      k++;
    end
    if (k >= 500) chk("write_stall_timeout", k, 0);
    mac_tx_we   = 1'b1;
    mac_tx_data = d;
    mac_tx_eof  = e;
    @(posedge clk);
    #1 last_wr_cyc = cyc;
  endtask

  task automatic idle_in();
    @(negedge clk);
    mac_tx_we  = 1'b0;
    mac_tx_eof = 4'b0;
  endtask

  task automatic send_frame();
    for (int i = 0; i < wq.size(); i++) write_word(wq[i], eq[i]);
    idle_in();
  endtask

  task automatic wait_frames(input int n);
    int k = 0;
    while (fr_len.size() < n && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (fr_len.size() < n) chk("frame_timeout", fr_len.size(), n);
  endtask

  task automatic wait_start(input int n);
    int k = 0;
    while (fr_first.size() < n && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (fr_first.size() < n) chk("start_timeout", fr_first.size(), n);
  endtask

  task automatic check_frame(input string tag, input int idx, input int exp_len);
    int s, l, nb, padend, bad;
    logic [7:0]  e;
    logic [31:0] r;
    if (idx >= fr_len.size()) return;
    s = fr_start[idx];
    l = fr_len[idx];
    chk({tag, "_len"}, l, exp_len);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      e = (i == 7) ? 8'hD5 : 8'h55;
      if (i >= l || rx_q[s + i] !== e) bad++;
    end
    chk({tag, "_preamble"}, bad, 0);
    nb = exp_q.size();
    padend = (nb < 60) ? 60 : nb;
    bad = 0;
    for (int i = 0; i < padend; i++) begin
      e = (i < nb) ? exp_q[i] : 8'h00;
      if (8 + i >= l || rx_q[s + 8 + i] !== e) bad++;
    end
    chk({tag, "_data_bad_bytes"}, bad, 0);
    r = 32'hFFFF_FFFF;
    for (int i = 8; i < l; i++) r = crc_byte(r, rx_q[s + i]);
    chk({tag, "_crc_residue"}, r, 32'hDEBB_20E3);
  endtask

  typedef struct {
    int         nwords;
    logic [3:0] eof;
    int         txlen;
  } vec_t;

  vec_t vt[7];

  initial begin
    int base, f0, fall, k;
    string tag;

    // {words, eof, expected tx_en cycles = 8 + max(data,60) + 4}
    vt[0] = '{10, 4'b0001, 72};
    vt[1] = '{15, 4'b0001, 72};
    vt[2] = '{16, 4'b1000, 73};
    vt[3] = '{16, 4'b0100, 74};
    vt[4] = '{16, 4'b0010, 75};
    vt[5] = '{16, 4'b0001, 76};
    vt[6] = '{1,  4'b1000, 72};

    repeat (3) @(negedge clk);
    chk("rst_stop", mac_tx_stop, 0);
    chk("rst_tx_en", gmii_tx_en, 0);
    chk("rst_txd", gmii_txd, 8'h00);
    chk("rst_tx_er", gmii_tx_er, 0);
    chk("rst_crc", dut.crc, 32'hFFFF_FFFF);
    chk("rst_pkt_count", dut.pkt_count, 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      base = fr_len.size();
      build(v + 1, vt[v].nwords, vt[v].eof);
      send_frame();
      wait_frames(base + 1);
      tag = $sformatf("vec%0d", v);
      if (fr_first.size() > base) chk({tag, "_start_latency"}, fr_first[base] - last_wr_cyc, 1);
      check_frame(tag, base, vt[v].txlen);
      chk({tag, "_tx_er"}, gmii_tx_er, 0);
      repeat (20) @(negedge clk);
    end

    // Back-to-back frames: exactly 12 idle cycles between last FCS byte and next preamble.
    base = fr_len.size();
    build(30, 10, 4'b0001); send_frame();
    build(31, 10, 4'b0001); send_frame();
    wait_frames(base + 2);
    if (fr_len.size() >= base + 2) chk("b2b_ifg_gap", fr_first[base + 1] - fr_last[base], 13);
    build(30, 10, 4'b0001); check_frame("b2b_a", base, 72);
    build(31, 10, 4'b0001); check_frame("b2b_b", base + 1, 72);
    repeat (20) @(negedge clk);

    // Next eof written on the very edge that pops the in-flight frame's eof word (first byte at F, pop at F+43).
    base = fr_len.size();
    build(40, 10, 4'b0001); send_frame();
    wait_start(base + 1);
    f0 = (fr_first.size() > base) ? fr_first[base] : cyc;
    build(41, 2, 4'b0100);
    write_word(wq[0], eq[0]);
    idle_in();
    k = 0;
    while (cyc != f0 + 42 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("same_edge_pkt_before", dut.pkt_count, 1);
    mac_tx_we = 1'b1; mac_tx_data = wq[1]; mac_tx_eof = eq[1];
    @(posedge clk);
    #1 chk("same_edge_pkt_after", dut.pkt_count, 1);
    idle_in();
    wait_frames(base + 2);
    if (fr_len.size() >= base + 2) chk("same_edge_ifg_gap", fr_first[base + 1] - fr_last[base], 13);
    build(40, 10, 4'b0001); check_frame("same_edge_a", base, 72);
    build(41, 2, 4'b0100);  check_frame("same_edge_b", base + 1, 72);
    repeat (20) @(negedge clk);

    // FIFO full: 16-word frame fills the FIFO; extra write dropped; stop falls after first pop (eof edge + 8).
    base = fr_len.size();
    build(50, 16, 4'b0001);
    for (int i = 0; i < 16; i++) write_word(wq[i], eq[i]);
    chk("full_stop_high", mac_tx_stop, 1);
    @(negedge clk);
    mac_tx_we = 1'b1; mac_tx_data = 32'hDEAD_BEEF; mac_tx_eof = 4'b0001;
    @(posedge clk);
    #1 chk("full_drop_stop", mac_tx_stop, 1);
    chk("full_drop_pkt_count", dut.pkt_count, 1);
    @(negedge clk);
    mac_tx_we = 1'b0; mac_tx_eof = 4'b0;
    fall = -1;
    for (int i = 0; i < 40; i++) begin
      if (!mac_tx_stop) begin
        fall = cyc;
        break;
      end
      @(negedge clk);
    end
    chk("full_stop_fall_cycle", fall - last_wr_cyc, 8);
    wait_frames(base + 1);
    check_frame("full", base, 76);
    repeat (20) @(negedge clk);

    // Reset during DATA byte 20: tx_en drops asynchronously, buffered words are discarded.
    base = fr_len.size();
    build(60, 10, 4'b0001); send_frame();
    wait_start(base + 1);
    f0 = (fr_first.size() > base) ? fr_first[base] : cyc;
    k = 0;
    while (cyc != f0 + 28 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("midrst_en_before", gmii_tx_en, 1);
    reset_n = 1'b0;
    #1;
    chk("midrst_en_async", gmii_tx_en, 0);
    chk("midrst_txd", gmii_txd, 8'h00);
    chk("midrst_stop", mac_tx_stop, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("midrst_pkt_count", dut.pkt_count, 0);
    chk("midrst_occ", dut.occ, 0);
    repeat (40) @(negedge clk);
    chk("midrst_no_stale_tx", fr_first.size(), base + 1);
    build(61, 10, 4'b0001); send_frame();
    wait_frames(base + 2);
    if (fr_first.size() > base + 1) chk("midrst_start_latency", fr_first[base + 1] - last_wr_cyc, 1);
    check_frame("midrst_new", base + 1, 72);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/mac_tx_gmii.md
MAC_TX_GMII -- requirements
Module: mac_tx_gmii

Interface
REQ-001 Parameter FIFO_AW, default 9, log2 of the word FIFO depth (DEPTH = 2^FIFO_AW words of 32 data + 4 eof bits).
REQ-002 Parameter IFG_CYCLES, default 12, minimum idle cycles between frames on GMII.
REQ-003 clk  input  1  single clock for all logic (125 MHz GMII TX clock).
REQ-004 reset_n  input  1  reset; asynchronous assert, active-low.
REQ-005 mac_tx_we  input  1  write strobe; one 32-bit word is accepted per cycle when high.
REQ-006 mac_tx_data  input  32  frame word, big-endian: [31:24] is transmitted first; the first word starts with the destination MAC.
REQ-007 mac_tx_eof  input  4  zero on non-final words; one-hot on the final word: bit0 = 4 valid bytes, bit1 = 3, bit2 = 2, bit3 = 1, counted from [31:24].
REQ-008 mac_tx_stop  output  1  back-pressure; upstream SHALL gate mac_tx_we with ~mac_tx_stop in the same cycle.
REQ-009 gmii_txd  output  8  transmit byte, registered.
REQ-010 gmii_tx_en  output  1  transmit enable, registered.
REQ-011 gmii_tx_er  output  1  transmit error, held 0.

Function
REQ-012 The block SHALL store each accepted word with its eof field in the FIFO.
REQ-013 mac_tx_stop SHALL equal (FIFO occupancy == DEPTH), combinationally from registered occupancy.
REQ-014 A write while mac_tx_stop=1 SHALL be dropped without corrupting FIFO state.
REQ-015 The block SHALL keep pkt_count, the number of complete frames in the FIFO.
- +1 on the edge that writes a word with eof != 0.
- -1 on the edge that pops a word with eof != 0.
- Simultaneous +1 and -1 SHALL leave pkt_count unchanged.
REQ-016 Upstream guarantees no frame longer than DEPTH words; otherwise stop stays high, and that deadlock is accepted behaviour.
REQ-017 Transmission is store-and-forward.
- The state machine SHALL leave IDLE only when pkt_count > 0.
- For eof written at edge E, gmii_tx_en SHALL first be 1 after edge E+1.
REQ-018 States and transitions: IDLE -> PRE -> SFD -> DATA -> (PAD if needed) -> FCS -> IFG -> IDLE.
- PRE: 7 cycles of 0x55.
- SFD: 1 cycle of 0xD5.
- DATA: valid bytes in order.
- PAD: 0x00 bytes until the data+pad count reaches 60.
- FCS: 4 bytes.
- IFG: IFG_CYCLES cycles with tx_en=0.
REQ-019 gmii_tx_en SHALL be 1 exactly in PRE, SFD, DATA, PAD and FCS, with no gap cycles.
- DATA SHALL therefore hold the next FIFO word before the current word's last byte (prefetch).
REQ-020 The FCS SHALL be IEEE 802.3 CRC-32 over DATA and PAD bytes.
- Reflected polynomial 0xEDB88320, init 0xFFFFFFFF, result complemented.
- The least-significant byte of the complemented CRC goes first.
REQ-021 Invalid bytes of the final word SHALL be discarded; no garbage bytes are transmitted.
REQ-022 The frame byte counter SHALL be 11 bits and saturate at 2047; saturation only affects the pad decision.
REQ-023 A new frame SHALL never start before IFG completes, even if pkt_count > 0 during IFG.
REQ-024 FIFO pointers SHALL wrap modulo DEPTH; full and empty SHALL be distinguished by an FIFO_AW+1 bit occupancy count.

Reset
REQ-025 While reset_n=0 the block SHALL hold this state:
- state = IDLE.
- FIFO empty, pkt_count = 0.
- mac_tx_stop = 0.
- gmii_txd = 0x00, gmii_tx_en = 0, gmii_tx_er = 0.
- CRC = 0xFFFFFFFF.
REQ-026 Reset asserted mid-frame SHALL drop gmii_tx_en immediately (asynchronously) and discard all buffered words.
- After release, the first frame SHALL start with a full preamble.

Verification
REQ-027 Write a 10-word frame (eof=0001 on word 10) -> 72 consecutive tx_en cycles:
- 7x55, D5.
- 40 data bytes matching the words MSB-first.
- 20x00 pad.
- 4 FCS bytes.
REQ-028 CRC residue over each received frame from DA through FCS SHALL equal 0xDEBB20E3, for frame lengths of 60, 61, 62, 63 and 64 data bytes (eof one-hot each of 0001, 1000, 0100, 0010).
REQ-029 Two frames written back-to-back -> second preamble begins exactly IFG_CYCLES=12 cycles after the first frame's last FCS byte.
REQ-030 Fill the FIFO with FIFO_AW=4 and GMII stalled by a pending frame -> mac_tx_stop=1 at occupancy 16.
- A write attempted while stopped is dropped.
- Stop falls the cycle after the first pop.
REQ-031 Assert reset_n=0 during DATA byte 20 -> tx_en=0 within the same cycle.
- After release, a new frame is transmitted correctly with 8 preamble/SFD bytes.
REQ-032 Write the eof word in the same cycle the previous frame's eof word is popped -> pkt_count stays 1 and the next frame follows after IFG.
